// File: rtl/cell_test_pkg.sv
// Shared types and constants for the standard-cell functional test sequencer.
package cell_test_pkg;

  localparam int VEC_W = 2;

  localparam logic [3:0] TT_NOR2   = 4'b0001;
  localparam logic [3:0] TT_NAND2  = 4'b0111;
  localparam logic [3:0] TT_INV_A1 = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cell_test_settle_cnt.sv
// Settle timer: loads CYCLES-1 and counts down; done is the terminal-count compare.
module cell_test_settle_cnt #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cell_test_seq.sv
// Sweeps all four {A2,A1} vectors through a 2-input cell and compares Y against
// a truth table latched at START, accumulating per-vector and total mismatches.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for START; results of the last run are held
// ST_APPLY  | new vector presented on A1/A2, settle timer loaded
// ST_SETTLE | vector held while the cell output settles
// ST_CHECK  | Y compared against latched TT; advance vector / pass count
// ST_DONE   | one-cycle DONE pulse, PASS valid
module cell_test_seq
  import cell_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       TT,
  input  logic             Y,
  output logic             A1,
  output logic             A2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_VEC
);

  localparam int PW = (PASSES > 0) ? $clog2(PASSES + 1) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("cell_test_seq: SETTLE_CYCLES must be at least 1");
  end
  if (PASSES < 1) begin : g_bad_passes
    $error("cell_test_seq: PASSES must be at least 1");
  end

  state_t           state;
  logic [VEC_W-1:0] idx;
  logic [PW-1:0]    pass_cnt;
  logic [3:0]       tt_q;
  logic             settle_done;
  logic             mismatch;
  logic             last_vec;
  logic             last_pass;
  logic [ERR_W-1:0] err_nxt;

  cell_test_settle_cnt #(
    .CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (CLK),
    .rst_n(RST_N),
    .load (state == ST_APPLY),
    .en   (state == ST_SETTLE),
    .done (settle_done)
  );

  assign mismatch  = (Y != tt_q[idx]);
  assign last_vec  = (idx == VEC_W'(3));
  assign last_pass = (pass_cnt == PW'(PASSES - 1));
  // Saturating increment; PASS is derived from this so the final check counts.
  assign err_nxt   = (mismatch && ERR_CNT != '1) ? ERR_CNT + ERR_W'(1) : ERR_CNT;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      tt_q     <= '0;
      A1       <= 1'b0;
      A2       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERR_CNT  <= '0;
      FAIL_VEC <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            tt_q     <= TT;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            PASS     <= 1'b0;
            idx      <= '0;
            pass_cnt <= '0;
            {A2, A1} <= '0;
            BUSY     <= 1'b1;
            state    <= ST_APPLY;
          end
        end
        ST_APPLY: state <= ST_SETTLE;
        ST_SETTLE: begin
          if (settle_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) FAIL_VEC[idx] <= 1'b1;
          ERR_CNT <= err_nxt;
          idx     <= idx + VEC_W'(1);
          if (last_vec) pass_cnt <= pass_cnt + PW'(1);
          if (last_vec && last_pass) begin
            state    <= ST_DONE;
            DONE     <= 1'b1;
            PASS     <= (err_nxt == '0);
            {A2, A1} <= '0;
          end else begin
            state    <= ST_APPLY;
            {A2, A1} <= idx + VEC_W'(1);
          end
        end
        ST_DONE: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_test_seq.sv
// Scoreboard bench: three sequencer configurations driven by randomized cell models.
module tb_cell_test_seq;
  import cell_test_pkg::*;

  localparam int NDUT = 3;
  localparam int SC_P [NDUT] = '{4, 4, 2};
  localparam int PA_P [NDUT] = '{1, 3, 2};
  localparam int EW_P [NDUT] = '{8, 8, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fin  = 0;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : u
    localparam int S = SC_P[g];
    localparam int P = PA_P[g];
    localparam int W = EW_P[g];
    localparam int N = 4 * P * (S + 2);

    typedef struct packed {
      logic [W-1:0] err;
      logic [3:0]   fv;
      logic         pass;
    } exp_t;

    logic         rst_n, start, y, a1, a2, busy, done, pass;
    logic [3:0]   tt, fail_vec, act_tt;
    logic [W-1:0] err_cnt;
    logic         glitch = 1'b1;
    logic         rnd = 1'b0;
    exp_t         exp_q[$];
    exp_t         last;
    exp_t         e;
    bit           have_last = 1'b0;
    bit           prev_start = 1'b0;
    bit           prev_rst = 1'b0;
    int           cyc = 0;

    cell_test_seq #(
      .SETTLE_CYCLES(S),
      .PASSES       (P),
      .ERR_W        (W)
    ) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .START   (start),
      .TT      (tt),
      .Y       (y),
      .A1      (a1),
      .A2      (a2),
      .BUSY    (busy),
      .DONE    (done),
      .PASS    (pass),
      .ERR_CNT (err_cnt),
      .FAIL_VEC(fail_vec)
    );

    // Cell under test; outside the compare cycle Y is noise the sequencer must ignore.
    assign y = glitch ? rnd : act_tt[{a2, a1}];

    function automatic exp_t model(input logic [3:0] t, input logic [3:0] a);
      exp_t r;
      int   n;
      n      = P * $countones(t ^ a);
      r.err  = (n > (2 ** W) - 1) ? W'((2 ** W) - 1) : W'(n);
      r.fv   = t ^ a;
      r.pass = (t == a);
      return r;
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic run(input logic [3:0] t, input logic [3:0] a);
      act_tt = a;
      tt     = t;
      start  = 1'b1;
      exp_q.push_back(model(t, a));
      step();
      for (int i = 0; i < N; i++) begin
        start = ($urandom_range(0, 3) == 0);
        tt    = 4'($urandom);
        step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
    endtask

    task automatic abort_run();
      act_tt = ~TT_NOR2;
      tt     = TT_NOR2;
      start  = 1'b1;
      exp_q.push_back(model(TT_NOR2, ~TT_NOR2));
      step();
      start = 1'b0;
      repeat (9) step();
      rst_n = 1'b0;
      start = 1'b1;
      step();
      rst_n = 1'b1;
      start = 1'b0;
      step();
    endtask

    initial begin : stim
      logic [3:0] t;
      rst_n  = 1'b0;
      start  = 1'b0;
      tt     = '0;
      act_tt = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      run(TT_NOR2, TT_NOR2);
      run(TT_NOR2, 4'b0000);
      run(TT_NOR2, 4'b1111);
      abort_run();
      run(TT_NAND2, TT_NAND2);
      run(TT_INV_A1, 4'($urandom));
      for (int k = 0; k < 6; k++) begin
        t = 4'($urandom);
        run(t, ($urandom_range(0, 1) == 1) ? t : 4'($urandom));
      end
      repeat (3) step();
      check("queue_empty", g, exp_q.size(), 0);
      n_fin++;
    end

    always @(negedge clk) begin
      if (!prev_rst) begin
        cyc = 0;
        exp_q.delete();
        have_last = 1'b0;
      end else if (cyc == 0) begin
        cyc = prev_start ? 1 : 0;
      end else if (cyc == N + 1) begin
        cyc = 0;
      end else begin
        cyc++;
      end
      prev_start = start;
      prev_rst   = rst_n;
      if (cyc == 1) have_last = 1'b0;

      check("busy", g, 32'(busy), 32'(cyc != 0));
      check("vec", g, 32'({a2, a1}), (cyc >= 1 && cyc <= N) ? ((cyc - 1) / (S + 2)) % 4 : 0);
      check("done", g, 32'(done), 32'(cyc == N + 1));

      if (cyc == 1 || (cyc == 0 && !have_last)) begin
        check("err_clr", g, 32'(err_cnt), 0);
        check("fv_clr", g, 32'(fail_vec), 0);
        check("pass_clr", g, 32'(pass), 0);
      end else if (cyc == 0) begin
        check("err_hold", g, 32'(err_cnt), 32'(last.err));
        check("fv_hold", g, 32'(fail_vec), 32'(last.fv));
        check("pass_hold", g, 32'(pass), 32'(last.pass));
      end

      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", g, 32'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("err_cnt", g, 32'(err_cnt), 32'(e.err));
          check("fail_vec", g, 32'(fail_vec), 32'(e.fv));
          check("pass", g, 32'(pass), 32'(e.pass));
          last      = e;
          have_last = 1'b1;
        end
      end

      glitch = !(cyc >= 1 && cyc <= N && ((cyc - 1) % (S + 2)) == S + 1);
      rnd    = 1'($urandom);
    end
  end

  initial begin : finisher
    int waited;
    waited = 0;
    while (n_fin < NDUT && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    check("all_finished", -1, n_fin, NDUT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
